greater_sort_stage: RTL
=======================

# greater_sort_stage

Downstream consumer of the 8-stage bit-serial pipelined greater-than comparator. It tracks every operand pair presented to the comparator and aligns it with the comparator's `r` output LAT cycles later. From each pair it produces an ordered (max, min) result and buffers it in an output FIFO behind a valid/ready handshake. Upstream flow is controlled by credits because the comparator itself cannot stall.

## Interface
Parameters:
- `LAT`, default 8: comparator latency, i.e. edges from operand sample to `r` update. Fixed by the comparator and must match it.
- `DEPTH`, default 16: output FIFO entries. Power of 2. DEPTH ≥ LAT+1 is required for full throughput.

Ports:
- `CLK` in 1: clock.
- `RST` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operand pair on `a`/`b` is offered this cycle.
- `in_ready` out 1: stage accepts the pair. A pair is accepted on `in_valid & in_ready`.
- `a`, `b` in 8: operands, wired to the comparator inputs in the same cycle.
- `r` in 1: comparator result (1 = a>b).
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: consumer pops the head.
- `max_o`, `min_o` out 8: ordered operands at the FIFO head.
- `gt_o` out 1: `r` captured for the head pair.
- `swap_cnt` out 16: present only with the statistics macro (see Configuration).

## Operation
- **Delay line:** LAT entries of {v, a, b}. Entry 0 loads {accept, a, b} every edge and entry i loads entry i-1. Every entry resets with v=0.
- **Alignment:** the tail entry and `r` refer to the same pair on every cycle.
- **Push:** when the tail entry has v=1, the stage pushes the following into the FIFO:
  - `gt` = `r`
  - `max` = r ? a : b
  - `min` = r ? b : a
  - When a==b, `r`=0, so max=min=a.
- **Comparator results with v=0 are discarded.** This covers pairs offered while `in_ready`=0 and the comparator's reset-state `r`.
- **Credit counter `used`:** counts FIFO occupancy plus in-flight valid entries, range 0..DEPTH.
  - +1 on accept, -1 on pop, unchanged when both occur in the same cycle.
  - `in_ready` = (`used` < DEPTH).
- **Push never overflows:** the credit counter guarantees this. A push with the FIFO full is an assertion failure.
- **FIFO:**
  - `out_valid` = FIFO non-empty. Pop on `out_valid & out_ready`.
  - Simultaneous push and pop leaves occupancy unchanged.
  - Pop when empty is ignored.
  - Read and write pointers wrap modulo DEPTH.
- **Output data:** `max_o`/`min_o`/`gt_o` show the head entry. They are undefined while `out_valid`=0 except after reset, when they are 0.
- **Ordering:** results leave strictly in acceptance order.
- **Reset values:** `in_ready`=1, `out_valid`=0, `max_o`=`min_o`=0, `gt_o`=0, `swap_cnt`=0, `used`=0, FIFO empty, all delay-line v=0.
- **Reset mid-operation:**
  - Every in-flight and buffered pair is lost.
  - No output appears for any of them after release.
  - The comparator shares RST and clears in step.

## Timing
- **Latency:** a pair accepted at edge n is in tail entry after edge n+LAT-1, where `r` for it is also valid. It is pushed at edge n+LAT. `out_valid` rises after edge n+LAT when the FIFO was empty, so latency is LAT+1 edges counting the sampling edge.
- **Throughput:** one pair per cycle when `out_ready`=1 and DEPTH ≥ LAT+1.
- **`in_ready`:** registered-state function of `used` only, with no combinational path from `out_ready`. A pop restores credit from the next cycle.
- **Handshake rule:** `in_valid` may be held while `in_ready`=0. The pair is accepted exactly once, in the cycle it sees `in_ready`=1.

## Configuration
- **`GREATER_SORT_STATS_EN` defined:**
  - `swap_cnt` port exists.
  - It increments on each push with gt=1 and saturates at 0xFFFF.
  - It clears only on RST.
- **Macro undefined:** the port and counter are absent. All other behaviour is identical.

## Structure
- **Package `greater_pkg`:**
  - `GREATER_W` = 8
  - `GREATER_LAT` = 8
  - struct `sort_entry_t` {max, min, gt}
  - struct `dly_entry_t` {v, a, b}
- **Sub-module `greater_sort_fifo`:**
  - Synchronous DEPTH×`sort_entry_t` FIFO with push/pop, full/empty and async active-low reset.
  - Delay line, credit counter and statistics stay in the top.

## Test plan
- **Reset:** hold RST=0, then release with no stimulus → `in_ready`=1, `out_valid`=0, `max_o`=`min_o`=0x00, `gt_o`=0 for 20 cycles.
- **Single pair:** a=0x80, b=0x7F accepted at edge n → `out_valid` rises after edge n+8 with `max_o`=0x80, `min_o`=0x7F, `gt_o`=1. Pop it → `out_valid`=0.
- **Equal and less:** accept 0x55/0x55 then 0x01/0xFE back-to-back → outputs in order:
  - (0x55, 0x55, gt=0)
  - (0xFE, 0x01, gt=0)
- **Back-pressure:** `out_ready`=0, `in_valid`=1 for 30 cycles →
  - Exactly 16 pairs accepted, `in_ready`=0 after the 16th, no further `r` captured.
  - Set `out_ready`=1 → all 16 drain in order, then `in_ready` returns to 1.
- **Full rate:** `out_ready`=1, 200 random back-to-back pairs → `in_ready` never deasserts and outputs match the model in order. With `GREATER_SORT_STATS_EN`, `swap_cnt` equals the count of a>b.
- **Mid-stream reset:** assert RST with 5 pairs in flight and 3 buffered → after release, zero outputs, `in_ready`=1 and `swap_cnt`=0.

Source files
------------

// File: rtl/greater_pkg.sv
// greater_pkg: shared widths, latency and record types for the greater-than sort stage.
package greater_pkg;
    localparam int GREATER_W   = 8;
    localparam int GREATER_LAT = 8;
    typedef struct packed {
        logic [GREATER_W-1:0] max;
        logic [GREATER_W-1:0] min;
        logic                 gt;
    } sort_entry_t;
    typedef struct packed {
        logic                 v;
        logic [GREATER_W-1:0] a;
        logic [GREATER_W-1:0] b;
    } dly_entry_t;
    localparam int SORT_W = $bits(sort_entry_t);
endpackage

// File: rtl/greater_sort_fifo.sv
// greater_sort_fifo: DEPTH-entry synchronous FIFO of sort results; head reads 0 while empty.
module greater_sort_fifo
    import greater_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_push,
    input  logic [SORT_W-1:0] i_data,
    input  logic              i_pop,
    output logic [SORT_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [SORT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr, r_rd;
    logic [AW:0]       r_cnt;
    logic              w_push, w_pop;
    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = o_empty ? '0 : r_mem[r_rd];
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/greater_sort_stage.sv
// greater_sort_stage: aligns accepted pairs with comparator r, orders them into a credit-controlled FIFO.
// Defining GREATER_SORT_STATS_EN adds the saturating swap_cnt output.
module greater_sort_stage
    import greater_pkg::*;
#(
    parameter int LAT   = GREATER_LAT,
    parameter int DEPTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [GREATER_W-1:0] a,
    input  logic [GREATER_W-1:0] b,
    input  logic                 r,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [GREATER_W-1:0] max_o,
    output logic [GREATER_W-1:0] min_o,
`ifdef GREATER_SORT_STATS_EN
    output logic [15:0]          swap_cnt,
`endif
    output logic                 gt_o
);
    localparam int UW = $clog2(DEPTH+1);
    dly_entry_t  r_dly [LAT];
    logic [UW-1:0] r_used;
    dly_entry_t  w_tail;
    sort_entry_t w_in, w_out;
    logic        w_accept, w_pop, w_push, w_full, w_empty;
    assign in_ready  = r_used < UW'(DEPTH);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;
    assign w_tail    = r_dly[LAT-1];
    assign w_push    = w_tail.v;
    assign w_in      = {r ? w_tail.a : w_tail.b, r ? w_tail.b : w_tail.a, r};
    assign {max_o, min_o, gt_o} = w_out;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < LAT; i++) r_dly[i] <= '0;
            r_used <= '0;
        end else begin
            r_dly[0] <= {w_accept, a, b};
            for (int i = 1; i < LAT; i++) r_dly[i] <= r_dly[i-1];
            r_used <= r_used + UW'(w_accept) - UW'(w_pop);
        end
    end
    greater_sort_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (w_push),
        .i_data  (w_in),
        .i_pop   (w_pop),
        .o_data  (w_out),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    // credits cover every in-flight pair, so a push can never meet a full FIFO
    ovf_a: assert property (@(posedge CLK) disable iff (!RST) !(w_push && w_full));
`ifdef GREATER_SORT_STATS_EN
    logic [15:0] r_swap;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_swap <= '0;
        else if (w_push && r && r_swap != 16'hFFFF) r_swap <= r_swap + 16'd1;
    end
    assign swap_cnt = r_swap;
`endif
endmodule
